// File: rtl/button_command_encoder_if.sv
// Command-side bundle of the button encoder: decoded button vector in, command handshake and e-stop out.
// The encoder takes the master modport; the consumer/stimulus side takes the slave modport.
interface button_command_encoder_if;
    logic [10:0] buttons;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [3:0]  cmd;
    logic        cmd_repeat;
    logic        estop;

    modport master (
        input  buttons,
        input  cmd_ready,
        output cmd_valid,
        output cmd,
        output cmd_repeat,
        output estop
    );

    modport slave (
        output buttons,
        output cmd_ready,
        input  cmd_valid,
        input  cmd,
        input  cmd_repeat,
        input  estop
    );
endinterface

// File: rtl/button_command_encoder.sv
// Turns the Genesis pad button vector into filtered, priority-encoded robot command events.
// Optional build macro CMD_AUTOREPEAT_EN adds auto-repeat of held motion/speed keys.
//
// state | meaning
// IDLE  | no pending event; waiting for the stable command to differ from the last one sent
// ISSUE | cmd_valid high; cmd/cmd_repeat frozen until the consumer takes it
// HELD  | repeatable key accepted and still held; repeat timer running (auto-repeat builds only)
module button_command_encoder #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
    input logic                      clk,
    input logic                      reset,
    button_command_encoder_if.master bus
);
    localparam logic [3:0] CODE_NONE      = 4'd0;
    localparam logic [3:0] CODE_FWD       = 4'd1;
    localparam logic [3:0] CODE_REV       = 4'd2;
    localparam logic [3:0] CODE_LEFT      = 4'd3;
    localparam logic [3:0] CODE_RIGHT     = 4'd4;
    localparam logic [3:0] CODE_BRUSH_ON  = 4'd5;
    localparam logic [3:0] CODE_BRUSH_OFF = 4'd6;
    localparam logic [3:0] CODE_SPRAY     = 4'd7;
    localparam logic [3:0] CODE_ESTOP     = 4'd8;
    localparam logic [3:0] CODE_SPD_UP    = 4'd9;
    localparam logic [3:0] CODE_SPD_DN    = 4'd10;
    localparam logic [3:0] CODE_CAM       = 4'd11;
    localparam logic [3:0] CODE_HALT      = 4'd12;

    localparam int unsigned   CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned   CNT_W1  = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W:0]   CNT_THR = CNT_W1'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1
`ifdef CMD_AUTOREPEAT_EN
        ,
        ST_HELD  = 2'd2
`endif
    } state_t;

    logic [10:0]      buttons_q;
    logic             estop_q;
    logic [3:0]       enc_code;
    logic [3:0]       prev_code;
    logic [CNT_W-1:0] stab_cnt;
    logic [CNT_W-1:0] stab_cnt_nxt;
    logic             stable_hit;
    logic [3:0]       stable_cmd;

    state_t     state, state_nxt;
    logic [3:0] cmd_q, cmd_nxt;
    logic [3:0] last_sent, last_nxt;
    logic       xfer;
    logic [3:0] sent_code;
    logic [3:0] ref_code;
    logic       ev_valid;
    logic       ev_clear;
    logic [3:0] ev_code;

`ifdef CMD_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TMR_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX + 1);
    // Loads are two short because entering ISSUE and the transfer itself each take one edge.
    localparam logic [TMR_W-1:0] DELAY_LOAD  = TMR_W'((REPEAT_DELAY  >= 2) ? REPEAT_DELAY  - 2 : 0);
    localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'((REPEAT_PERIOD >= 2) ? REPEAT_PERIOD - 2 : 0);

    logic             rep_q, rep_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;

    function automatic logic repeatable(input logic [3:0] code);
        return ((code >= CODE_FWD) && (code <= CODE_RIGHT)) ||
               (code == CODE_SPD_UP) || (code == CODE_SPD_DN);
    endfunction
`endif

    always_comb begin
        enc_code = CODE_NONE;
        if      (buttons_q[7])  enc_code = CODE_ESTOP;
        else if (buttons_q[4])  enc_code = CODE_BRUSH_ON;
        else if (buttons_q[5])  enc_code = CODE_BRUSH_OFF;
        else if (buttons_q[6])  enc_code = CODE_SPRAY;
        else if (buttons_q[8])  enc_code = CODE_SPD_UP;
        else if (buttons_q[9])  enc_code = CODE_SPD_DN;
        else if (buttons_q[10]) enc_code = CODE_CAM;
        else if (buttons_q[0])  enc_code = CODE_FWD;
        else if (buttons_q[1])  enc_code = CODE_REV;
        else if (buttons_q[2])  enc_code = CODE_LEFT;
        else if (buttons_q[3])  enc_code = CODE_RIGHT;
    end

    // stab_cnt_nxt + 1 is the number of cycles the current code has been present.
    always_comb begin
        stab_cnt_nxt = '0;
        if (enc_code == prev_code) begin
            if (stab_cnt == CNT_SAT) stab_cnt_nxt = stab_cnt;
            else                     stab_cnt_nxt = stab_cnt + 1'b1;
        end
        stable_hit = (({1'b0, stab_cnt_nxt} + 1'b1) >= CNT_THR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buttons_q  <= '0;
            estop_q    <= 1'b0;
            prev_code  <= CODE_NONE;
            stab_cnt   <= '0;
            stable_cmd <= CODE_NONE;
        end else begin
            buttons_q <= bus.buttons;
            estop_q   <= buttons_q[7];
            prev_code <= enc_code;
            stab_cnt  <= stab_cnt_nxt;
            if (stable_hit) stable_cmd <= enc_code;
        end
    end

    // On a transfer the evaluator compares against what is about to be recorded, so a
    // change coalesced during ISSUE can be re-issued without an idle cycle.
    always_comb begin
        xfer      = (state == ST_ISSUE) && bus.cmd_ready;
        sent_code = (cmd_q == CODE_HALT) ? CODE_NONE : cmd_q;
        ref_code  = xfer ? sent_code : last_sent;
        ev_valid  = 1'b0;
        ev_clear  = 1'b0;
        ev_code   = CODE_NONE;
        if (stable_cmd != ref_code) begin
            if (stable_cmd != CODE_NONE) begin
                ev_valid = 1'b1;
                ev_code  = stable_cmd;
            end else if ((ref_code >= CODE_FWD) && (ref_code <= CODE_RIGHT)) begin
                ev_valid = 1'b1;
                ev_code  = CODE_HALT;
            end else begin
                ev_clear = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        last_nxt  = last_sent;
`ifdef CMD_AUTOREPEAT_EN
        rep_nxt   = rep_q;
        timer_nxt = (timer != '0) ? timer - 1'b1 : timer;
`endif
        unique case (state)
            ST_IDLE: begin
                if (ev_valid) begin
                    state_nxt = ST_ISSUE;
                    cmd_nxt   = ev_code;
`ifdef CMD_AUTOREPEAT_EN
                    rep_nxt   = 1'b0;
`endif
                end else if (ev_clear) begin
                    last_nxt = CODE_NONE;
                end
            end
            ST_ISSUE: begin
                if (xfer) begin
                    last_nxt = sent_code;
                    if (ev_valid) begin
                        cmd_nxt = ev_code;
`ifdef CMD_AUTOREPEAT_EN
                        rep_nxt = 1'b0;
`endif
                    end else if (ev_clear) begin
                        last_nxt  = CODE_NONE;
                        state_nxt = ST_IDLE;
`ifdef CMD_AUTOREPEAT_EN
                    end else if (repeatable(cmd_q)) begin
                        state_nxt = ST_HELD;
                        timer_nxt = rep_q ? PERIOD_LOAD : DELAY_LOAD;
`endif
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
`ifdef CMD_AUTOREPEAT_EN
            ST_HELD: begin
                if (ev_valid) begin
                    state_nxt = ST_ISSUE;
                    cmd_nxt   = ev_code;
                    rep_nxt   = 1'b0;
                end else if (ev_clear) begin
                    last_nxt  = CODE_NONE;
                    state_nxt = ST_IDLE;
                end else if (timer == '0) begin
                    state_nxt = ST_ISSUE;
                    cmd_nxt   = last_sent;
                    rep_nxt   = 1'b1;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd_q     <= CODE_NONE;
            last_sent <= CODE_NONE;
`ifdef CMD_AUTOREPEAT_EN
            rep_q     <= 1'b0;
            timer     <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cmd_q     <= cmd_nxt;
            last_sent <= last_nxt;
`ifdef CMD_AUTOREPEAT_EN
            rep_q     <= rep_nxt;
            timer     <= timer_nxt;
`endif
        end
    end

    assign bus.cmd_valid = (state == ST_ISSUE);
    assign bus.cmd       = cmd_q;
    assign bus.estop     = estop_q;
`ifdef CMD_AUTOREPEAT_EN
    assign bus.cmd_repeat = rep_q;
`else
    assign bus.cmd_repeat = 1'b0;
`endif
endmodule

// File: tb/tb_button_command_encoder.sv
// Bench for button_command_encoder: directed timing checks plus a randomized button stream
// checked against an event-level reference model.
module tb_button_command_encoder;
    localparam int SC = 4;
    localparam int RD = 10;
    localparam int RP = 4;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    button_command_encoder_if bif ();

    button_command_encoder #(
        .STABLE_CYCLES(SC),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    always #5 clk = ~clk;

    logic [3:0] obs_q[$];
    logic [3:0] exp_q[$];
    logic [3:0] code_log[$];
    bit         mon_en = 1'b0;

    always @(negedge clk)
        if (mon_en && bif.cmd_valid && bif.cmd_ready && !bif.cmd_repeat) obs_q.push_back(bif.cmd);

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int max_ticks, output int n);
        n = 0;
        for (int i = 1; i <= max_ticks && n == 0; i++) begin
            tick();
            if (bif.cmd_valid === 1'b1) n = i;
        end
    endtask

    task automatic wait_code(input logic [3:0] code, input int max_ticks, output int n);
        n = 0;
        for (int i = 1; i <= max_ticks && n == 0; i++) begin
            tick();
            if (bif.cmd_valid === 1'b1 && bif.cmd === code) n = i;
        end
    endtask

    // Priority order as a plain list: button index -> command code is index + 1.
    function automatic logic [3:0] ref_enc(input logic [10:0] b);
        int prio[11] = '{7, 4, 5, 6, 8, 9, 10, 0, 1, 2, 3};
        for (int i = 0; i < 11; i++)
            if (b[prio[i]]) return 4'(prio[i] + 1);
        return 4'd0;
    endfunction

    task automatic drive(input logic [10:0] b);
        bif.buttons = b;
        code_log.push_back(ref_enc(b));
        tick();
    endtask

    // Collapse the per-cycle code log into runs; a run of SC cycles becomes the stable command.
    task automatic build_expected();
        logic [3:0] stable;
        logic [3:0] last;
        logic [3:0] run_code;
        int         run_len;
        stable = 4'd0; last = 4'd0; run_code = 4'd0; run_len = 0;
        exp_q.delete();
        foreach (code_log[i]) begin
            if (code_log[i] == run_code) run_len++;
            else begin
                run_code = code_log[i];
                run_len  = 1;
            end
            if (run_len == SC && run_code != stable) begin
                stable = run_code;
                if (stable != last) begin
                    if (stable != 4'd0) begin
                        exp_q.push_back(stable);
                        last = stable;
                    end else if (last >= 4'd1 && last <= 4'd4) begin
                        exp_q.push_back(4'd12);
                        last = 4'd0;
                    end else begin
                        last = 4'd0;
                    end
                end
            end
        end
    endtask

    initial begin
        int         n;
        int         bad;
        int         t;
        int         xfer_t[$];
        logic       xfer_r[$];
        int         exp_t[$];
        logic       exp_r[$];
        logic [10:0] pat;
        int         len;

        reset = 1'b1;
        bif.buttons = '0;
        bif.cmd_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", bif.cmd_valid, 0);
        check("rst_cmd", bif.cmd, 0);
        check("rst_repeat", bif.cmd_repeat, 0);
        check("rst_estop", bif.estop, 0);
        reset = 1'b0;
        repeat (3) tick();

        // 1: press-to-valid latency and single-cycle pulse, then HALT on release
        bif.buttons = 11'h001;
        wait_valid(20, n);
        check("t1_latency", n, SC + 2);
        check("t1_cmd", bif.cmd, 1);
        check("t1_repeat", bif.cmd_repeat, 0);
        tick();
        check("t1_pulse", bif.cmd_valid, 0);
        bif.buttons = '0;
        wait_code(4'd12, 20, n);
        check("t1_halt_latency", n, SC + 2);
        repeat (10) tick();

        // 2: short glitch is filtered; A beats up
        bif.buttons = 11'h001;
        bad = 0;
        repeat (3) begin tick(); if (bif.cmd_valid !== 1'b0) bad++; end
        bif.buttons = '0;
        repeat (10) begin tick(); if (bif.cmd_valid !== 1'b0) bad++; end
        check("t2_glitch_valid_cycles", bad, 0);
        bif.buttons = 11'h011;
        wait_valid(20, n);
        check("t2_latency", n, SC + 2);
        check("t2_priority_cmd", bif.cmd, 5);
        tick();
        bif.buttons = '0;
        bad = 0;
        repeat (12) begin tick(); if (bif.cmd_valid !== 1'b0) bad++; end
        check("t2_no_halt_after_A", bad, 0);

        // 3: backpressure freezes cmd; change coalesces and issues right after transfer
        bif.cmd_ready = 1'b0;
        bif.buttons = 11'h001;
        wait_valid(20, n);
        check("t3_cmd_first", bif.cmd, 1);
        bif.buttons = 11'h002;
        bad = 0;
        repeat (10) begin tick(); if (!(bif.cmd_valid === 1'b1 && bif.cmd === 4'd1)) bad++; end
        check("t3_frozen_cycles", bad, 0);
        bif.cmd_ready = 1'b1;
        tick();
        check("t3_next_valid", bif.cmd_valid, 1);
        check("t3_next_cmd", bif.cmd, 2);
        tick();
        bif.buttons = '0;
        wait_code(4'd12, 30, n);
        check("t3_halt_seen", n != 0, 1);
        repeat (10) tick();

        // 4: B press/release gives one event and no HALT
        bif.buttons = 11'h020;
        wait_valid(20, n);
        check("t4_cmd_B", bif.cmd, 6);
        tick();
        bif.buttons = '0;
        bad = 0;
        repeat (12) begin tick(); if (bif.cmd_valid !== 1'b0) bad++; end
        check("t4_no_halt_after_B", bad, 0);

        // 5: held up -> transfer schedule, measured in edges from the press
        bif.buttons = 11'h001;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (bif.cmd_valid === 1'b1) begin
                xfer_t.push_back(e + 1);
                xfer_r.push_back(bif.cmd_repeat);
            end
        end
        t = SC + 3;
        exp_t.push_back(t);
        exp_r.push_back(1'b0);
`ifdef CMD_AUTOREPEAT_EN
        t = t + RD;
        while (t <= 41) begin
            exp_t.push_back(t);
            exp_r.push_back(1'b1);
            t = t + RP;
        end
`endif
        check("t5_xfer_count", xfer_t.size(), exp_t.size());
        for (int i = 0; i < exp_t.size() && i < xfer_t.size(); i++) begin
            check($sformatf("t5_xfer_edge%0d", i), xfer_t[i], exp_t[i]);
            check($sformatf("t5_xfer_rep%0d", i), xfer_r[i], exp_r[i]);
        end
        bif.buttons = '0;
        wait_code(4'd12, 30, n);
        check("t5_halt_seen", n != 0, 1);
        repeat (10) tick();

        // 6: reset drops a pending event; estop and ESTOP command latencies
        bif.cmd_ready = 1'b0;
        bif.buttons = 11'h001;
        wait_valid(20, n);
        check("t6_pending", bif.cmd_valid, 1);
        reset = 1'b1;
        bif.buttons = '0;
        tick();
        check("t6_rst_valid", bif.cmd_valid, 0);
        check("t6_rst_cmd", bif.cmd, 0);
        reset = 1'b0;
        bif.cmd_ready = 1'b1;
        repeat (3) tick();
        check("t6_no_halt_after_reset", bif.cmd_valid, 0);
        bif.buttons = 11'h080;
        tick();
        check("t6_estop_edge1", bif.estop, 0);
        tick();
        check("t6_estop_edge2", bif.estop, 1);
        wait_valid(10, n);
        check("t6_cmd_latency", n + 2, SC + 2);
        check("t6_cmd_estop", bif.cmd, 8);
        tick();
        bif.buttons = '0;
        repeat (15) tick();

        // Randomized stream against the event-level model
        code_log.delete();
        obs_q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) drive('0);
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 3))
                0:       pat = '0;
                1:       pat = 11'(1) << $urandom_range(0, 10);
                2:       pat = 11'($urandom);
                default: pat = (11'(1) << $urandom_range(0, 10)) | (11'(1) << $urandom_range(0, 10));
            endcase
            len = ($urandom_range(0, 9) < 7) ? int'($urandom_range(5, 14)) : int'($urandom_range(1, 3));
            for (int c = 0; c < len; c++) drive(pat);
        end
        for (int i = 0; i < 25; i++) drive('0);
        mon_en = 1'b0;
        build_expected();
        check("rand_event_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("rand_event%0d", i), obs_q[i], exp_q[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
